float_normalize: RTL and testbench
==================================

FLOAT_NORMALIZE -- requirements
Module: float_normalize

Interface
REQ-001 SHALL have parameter Nm, default 23, mantissa width without the hidden bit.
REQ-002 SHALL have parameter Ne, default 8, exponent width; bias is 2**(Ne-1)-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream adder/subtractor presents an unnormalised result.
REQ-006 SHALL have port in_ready, output, 1, block accepts the input this cycle.
REQ-007 SHALL have port in_sum, input, Nm+3, two's-complement mantissa sum; magnitude = |in_sum| * 2**-Nm (hidden-bit weight at bit Nm, carry at bit Nm+1).
REQ-008 SHALL have port in_exp, input, Ne, biased exponent of the larger operand.
REQ-009 SHALL have port out_valid, output, 1, normalised result available.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-011 SHALL have port out_float, output, 1+Ne+Nm, packed {sign, exponent, mantisse}.
REQ-012 SHALL have port out_ovf, output, 1, result saturated; qualified by out_valid.
REQ-013 SHALL have port out_unf, output, 1, result flushed to zero by underflow; qualified by out_valid.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 = sign extraction, absolute value, leading-one index p; S2 = shift, exponent adjust, saturate/flush, output register.
REQ-015 SHALL transfer input when in_valid && in_ready and output when out_valid && out_ready.
REQ-016 SHALL give latency exactly 2 cycles from input transfer to out_valid when out_ready stays high, with throughput of one result per cycle.
REQ-017 SHALL advance S2 when S2 is empty or out_ready=1, and advance S1 when S1 is empty or S2 advances; in_ready SHALL equal the S1 advance condition, which depends combinationally on out_ready.
REQ-018 SHALL hold out_float, out_ovf and out_unf stable while out_valid=1 and out_ready=0.
REQ-019 SHALL neither drop, duplicate nor reorder transactions.
REQ-020 SHALL take sign = in_sum[Nm+2] and mag = |in_sum|, using Nm+2 bits.
REQ-021 SHALL, when mag=0, output sign 0, exponent 0, mantisse 0, with ovf=0 and unf=0.
REQ-022 SHALL, when p=Nm+1, set mantisse = mag[Nm:1] (truncated) and exponent = in_exp+1.
REQ-023 SHALL, when p=Nm, set mantisse = mag[Nm-1:0] and exponent = in_exp.
REQ-024 SHALL, when p<Nm, shift mag left by Nm-p, set mantisse = shifted[Nm-1:0] and exponent = in_exp-(Nm-p).
REQ-025 SHALL compute the new exponent in at least Ne+2 signed bits with no wrap.
REQ-026 SHALL, when the new exponent exceeds 2**Ne-2, output exponent 2**Ne-2, mantisse all ones, input sign, and out_ovf=1.
REQ-027 SHALL, when the new exponent is below 1, output the all-zero float (sign 0) with out_unf=1; exponent 0 is reserved for zero.
REQ-028 SHALL round by truncation only.

Reset
REQ-029 SHALL, while reset_n=0, clear both stage valids, drive out_valid=0, out_float=0, out_ovf=0 and out_unf=0, and hold in_ready=1 once reset is released.
REQ-030 SHALL discard any in-flight data on reset assertion mid-operation, with no output after release until new input is accepted.

Verification (Nm=23, Ne=8)
REQ-031 SHALL check carry: in_sum=0x1800000, in_exp=127, out_ready=1 -> 2 cycles later out_float=0x40400000 (3.0), ovf=0, unf=0.
REQ-032 SHALL check cancellation and negative: in_sum=0x0100000, in_exp=127 -> 0x3E000000; in_sum=0x3800000, in_exp=130 -> 0xC1000000.
REQ-033 SHALL check limits: in_sum=0x1000000, in_exp=254 -> 0x7F7FFFFF with ovf=1; in_sum=0x1, in_exp=10 -> 0x00000000 with unf=1; in_sum=0 -> 0x00000000 with no flags.
REQ-034 SHALL check backpressure: stream 4 inputs with out_ready=0 for 6 cycles -> in_ready falls after 2 accepted, out_float stable, all 4 outputs emerge in order after out_ready=1.
REQ-035 SHALL check back-to-back: 100 random inputs with random in_valid/out_ready -> every output matches a reference model implementing REQ-020..028, none lost.
REQ-036 SHALL check mid-reset: reset_n pulsed low with both stages full -> out_valid=0 asynchronously, no stale output after release.

Source files
------------

// File: rtl/float_normalize.sv
`default_nettype none
// ============================================================================
// float_normalize : two-stage normaliser for adder/subtractor mantissa sums
// Revision        : 1.0
// ============================================================================
module float_normalize #(
    parameter int Nm = 23,
    parameter int Ne = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Nm+2:0]    in_sum,
    input  logic [Ne-1:0]    in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Ne+Nm:0]   out_float,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam int PW = $clog2(Nm + 2);
    localparam int EW = Ne + 2;
    localparam logic signed [EW-1:0] c_exp_max = EW'(2 ** Ne - 2);
    localparam logic signed [EW-1:0] c_exp_min = EW'(1);

    logic                   r_v1;
    logic                   r_sign1;
    logic [Nm+1:0]          r_mag1;
    logic [PW-1:0]          r_p1;
    logic [Ne-1:0]          r_exp1;
    logic                   r_v2;
    logic [Ne+Nm:0]         r_float;
    logic                   r_ovf;
    logic                   r_unf;

    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic                   w_sign;
    logic [Nm+1:0]          w_mag;
    logic [PW-1:0]          w_p;
    logic [PW-1:0]          w_sh;
    logic [Nm-1:0]          w_mant;
    logic signed [EW-1:0]   w_exp_new;
    logic [Ne+Nm:0]         w_float;
    logic                   w_ovf;
    logic                   w_unf;

    assign w_s2_adv  = !r_v2 || out_ready;
    assign w_s1_adv  = !r_v1 || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_v2;
    assign out_float = r_float;
    assign out_ovf   = r_ovf;
    assign out_unf   = r_unf;

    // Stage 1: sign, magnitude and leading-one position
    assign w_sign = in_sum[Nm+2];
    assign w_mag  = (Nm + 2)'(w_sign ? -in_sum : in_sum);

    always_comb begin
        w_p = '0;
        for (int i = 0; i < Nm + 2; i++) begin
            if (w_mag[i]) begin
                w_p = PW'(i);
            end
        end
    end

    // Stage 2: shift, exponent adjust in a widened signed range, then clamp
    always_comb begin
        w_sh      = '0;
        w_mant    = '0;
        w_exp_new = '0;
        if (r_p1 == PW'(Nm + 1)) begin
            w_mant    = r_mag1[Nm:1];
            w_exp_new = EW'(r_exp1) + EW'(1);
        end else begin
            w_sh      = PW'(Nm) - r_p1;
            w_mant    = Nm'(r_mag1 << w_sh);
            w_exp_new = EW'(r_exp1) - EW'(w_sh);
        end
        w_float = {r_sign1, w_exp_new[Ne-1:0], w_mant};
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        if (r_mag1 == '0) begin
            w_float = '0;
        end else if (w_exp_new > c_exp_max) begin
            w_float = {r_sign1, c_exp_max[Ne-1:0], {Nm{1'b1}}};
            w_ovf   = 1'b1;
        end else if (w_exp_new < c_exp_min) begin
            w_float = '0;
            w_unf   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
            r_p1    <= '0;
            r_exp1  <= '0;
            r_v2    <= 1'b0;
            r_float <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_sign1 <= w_sign;
                    r_mag1  <= w_mag;
                    r_p1    <= w_p;
                    r_exp1  <= in_exp;
                end
            end
            if (w_s2_adv) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_float <= w_float;
                    r_ovf   <= w_ovf;
                    r_unf   <= w_unf;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_normalize.sv
`default_nettype none
// ============================================================================
// tb_float_normalize : self-checking bench with scoreboard and reference model
// Revision           : 1.0
// ============================================================================
module tb_float_normalize;

    localparam int NM = 23;
    localparam int NE = 8;
    localparam int FW = 1 + NE + NM;
    localparam int XW = FW + 2;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [NM+2:0]   in_sum;
    logic [NE-1:0]   in_exp;
    logic            out_valid;
    logic            out_ready;
    logic [FW-1:0]   out_float;
    logic            out_ovf;
    logic            out_unf;

    int              checks = 0;
    int              errors = 0;
    logic [XW-1:0]   q[$];
    logic [XW-1:0]   cur_exp;
    logic [XW-1:0]   held;
    logic            stall_prev = 1'b0;

    float_normalize #(.Nm(NM), .Ne(NE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: renormalise the magnitude by halving/doubling, returns {float, ovf, unf}
    function automatic logic [XW-1:0] model(input logic [NM+2:0] s, input logic [NE-1:0] e);
        longint mag;
        longint m;
        int     ex;
        logic   sg;
        sg  = s[NM+2];
        mag = sg ? ((longint'(1) << (NM + 3)) - longint'(s)) : longint'(s);
        mag = mag % (longint'(1) << (NM + 2));
        if (mag == 0) return '0;
        m  = mag;
        ex = int'(e);
        while (m >= (longint'(1) << (NM + 1))) begin
            m  = m / 2;
            ex = ex + 1;
        end
        while (m < (longint'(1) << NM)) begin
            m  = m * 2;
            ex = ex - 1;
        end
        if (ex > 2 ** NE - 2) return {sg, NE'(2 ** NE - 2), {NM{1'b1}}, 2'b10};
        if (ex < 1) return {FW'(0), 2'b01};
        return {sg, NE'(ex), NM'(m - (longint'(1) << NM)), 2'b00};
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Scoreboard and output-stability checking, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && stall_prev)
                check_val("hold", {out_float, out_ovf, out_unf}, held);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output: got %h, want none", out_float);
                end else begin
                    check_val("result", {out_float, out_ovf, out_unf}, q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_float, out_ovf, out_unf};
            if (in_valid && in_ready) q.push_back(cur_exp);
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [NM+2:0] s, input logic [NE-1:0] e,
                        input logic [XW-1:0] want, input bit rnd);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sum   = s;
        in_exp   = e;
        cur_exp  = want;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send timeout: in_ready got 0, want 1");
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic idle(input bit rnd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
    endtask

    logic [NM+2:0] bp_sum [4];
    logic [NE-1:0] bp_exp [4];

    initial begin
        int k;
        logic [NM+2:0] s;
        logic [NE-1:0] e;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        cur_exp   = '0;

        repeat (2) @(negedge clk);
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset out_float", 64'(out_float), 64'd0);
        check_val("reset flags", 64'({out_ovf, out_unf}), 64'd0);
        check_val("reset in_ready", 64'(in_ready), 64'd1);

        check_val("model carry", 64'(model(26'h1800000, 8'd127)), 64'({32'h40400000, 2'b00}));
        check_val("model cancel", 64'(model(26'h0100000, 8'd127)), 64'({32'h3E000000, 2'b00}));
        check_val("model negative", 64'(model(26'h3800000, 8'd130)), 64'({32'hC1000000, 2'b00}));
        check_val("model ovf", 64'(model(26'h1000000, 8'd254)), 64'({32'h7F7FFFFF, 2'b10}));
        check_val("model unf", 64'(model(26'h0000001, 8'd10)), 64'({32'h00000000, 2'b01}));
        check_val("model zero", 64'(model(26'h0000000, 8'd55)), 64'({32'h00000000, 2'b00}));

        @(posedge clk); #1;
        reset_n = 1'b1;

        send(26'h1800000, 8'd127, {32'h40400000, 2'b00}, 1'b0);
        send(26'h0100000, 8'd127, {32'h3E000000, 2'b00}, 1'b0);
        send(26'h3800000, 8'd130, {32'hC1000000, 2'b00}, 1'b0);
        send(26'h1000000, 8'd254, {32'h7F7FFFFF, 2'b10}, 1'b0);
        send(26'h0000001, 8'd10,  {32'h00000000, 2'b01}, 1'b0);
        send(26'h0000000, 8'd55,  {32'h00000000, 2'b00}, 1'b0);
        drain();

        // Backpressure: four inputs offered while the consumer stalls
        bp_sum[0] = 26'h0C00000; bp_exp[0] = 8'd100;
        bp_sum[1] = 26'h3F00000; bp_exp[1] = 8'd90;
        bp_sum[2] = 26'h0000400; bp_exp[2] = 8'd60;
        bp_sum[3] = 26'h1FFFFFF; bp_exp[3] = 8'd3;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sum   = bp_sum[k];
            in_exp   = bp_exp[k];
            cur_exp  = model(bp_sum[k], bp_exp[k]);
            @(negedge clk);
            if (in_ready) k++;
        end
        check_val("bp accepted", 64'(k), 64'd2);
        check_val("bp in_ready", 64'(in_ready), 64'd0);
        check_val("bp out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && k < 4; c++) begin
            in_valid = 1'b1;
            in_sum   = bp_sum[k];
            in_exp   = bp_exp[k];
            cur_exp  = model(bp_sum[k], bp_exp[k]);
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        check_val("bp all accepted", 64'(k), 64'd4);
        drain();

        // Random stream with random gaps and random consumer stalls
        for (int i = 0; i < 100; i++) begin
            s = (NM + 3)'($urandom() >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) s = -s;
            e = NE'($urandom_range(0, 255));
            send(s, e, model(s, e), 1'b1);
            if ($urandom_range(0, 3) == 0) idle(1'b1);
        end
        drain();

        // Reset asserted with both stages holding data
        out_ready = 1'b0;
        send(26'h0400000, 8'd20, model(26'h0400000, 8'd20), 1'b0);
        send(26'h0200000, 8'd21, model(26'h0200000, 8'd21), 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("midreset full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midreset out_valid", 64'(out_valid), 64'd0);
        check_val("midreset out_float", 64'({out_float, out_ovf, out_unf}), 64'd0);
        q.delete();
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("post-reset silent", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
